// File: rtl/axi_ring_writer_if.sv
// AXI3 write-channel bundle (AW, W, B) between the ring writer and a memory slave.
interface axi_ring_writer_if #(
    parameter int DW = 64
);
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_ring_writer.sv
// Packs SW-bit samples into DW-bit words, buffers them in a FIFO and streams
// fixed-length AXI3 INCR bursts into a circular buffer in memory.
module axi_ring_writer #(
    parameter int SW     = 32,
    parameter int DW     = 64,
    parameter int BURST  = 16,
    parameter int FDEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [31:0]          base,
    input  logic [31:0]          size,
    input  logic [SW-1:0]        in_data,
    input  logic                 in_valid,
    axi_ring_writer_if.master    axi,
    output logic [31:0]          wr_off,
    output logic [31:0]          wrap_cnt,
    output logic [31:0]          beat_cnt,
    output logic                 ovf,
    output logic                 resp_err,
    output logic                 busy
);
    localparam int K     = DW / SW;
    localparam int LW    = (K > 1) ? $clog2(K) : 1;
    localparam int AW    = $clog2(FDEPTH);
    localparam int BYTES = BURST * DW / 8;

    localparam logic [AW:0]   LVL_BURST = (AW+1)'(BURST);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FDEPTH);
    localparam logic [4:0]    BEAT_LAST = 5'(BURST - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(K - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]    state;
    logic          run;
    logic          start;
    logic          accept;
    logic          lane_end;
    logic [LW-1:0] lane;
    logic [DW-1:0] pack_p0;
    logic [DW-1:0] pack_nx;
    logic [DW-1:0] word_p1;
    logic          vld_p1;

    logic [DW-1:0] mem [FDEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   level;
    logic          full;
    logic          push;
    logic          pop;
    logic          wr_en;

    logic [4:0]    beat;
    logic [31:0]   awaddr_r;
    logic          awvalid_r;
    logic [31:0]   off_nx;

    assign start    = (state == S_IDLE) && en && !run;
    assign accept   = in_valid && run;
    assign lane_end = (lane == LANE_LAST);

    always_comb begin
        pack_nx = pack_p0;
        pack_nx[SW*int'(lane) +: SW] = in_data;
    end

    // p0: lane accumulation; p1: completed word waiting for its FIFO write
    always_ff @(posedge clk) begin
        if (accept) begin
            pack_p0 <= pack_nx;
            if (lane_end) word_p1 <= pack_nx;
        end
        if (wr_en) mem[wptr[AW-1:0]] <= word_p1;
    end

    assign level = wptr - rptr;
    assign full  = (level == LVL_FULL);
    assign pop   = axi.wvalid && axi.wready;
    assign push  = vld_p1 && !start;
    // A pop in the same cycle frees the slot being written, so it is not an overflow.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            lane   <= '0;
            vld_p1 <= 1'b0;
            wptr   <= '0;
            rptr   <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) lane <= lane_end ? '0 : LW'(lane + 1'b1);
            vld_p1 <= accept && lane_end;
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && !wr_en) ovf <= 1'b1;
        end
    end

    assign off_nx = wr_off + 32'(BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            run       <= 1'b0;
            awvalid_r <= 1'b0;
            awaddr_r  <= '0;
            beat      <= '0;
            wr_off    <= '0;
            wrap_cnt  <= '0;
            beat_cnt  <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        run      <= 1'b1;
                        wr_off   <= '0;
                        wrap_cnt <= '0;
                        beat_cnt <= '0;
                        resp_err <= 1'b0;
                    end else if (!en) begin
                        run <= 1'b0;
                    end else if (run && level >= LVL_BURST) begin
                        state     <= S_AW;
                        awvalid_r <= 1'b1;
                        awaddr_r  <= base + wr_off;
                    end
                end
                S_AW: begin
                    if (axi.awready) begin
                        awvalid_r <= 1'b0;
                        state     <= S_W;
                        beat      <= '0;
                        if (off_nx == size) begin
                            wr_off   <= '0;
                            wrap_cnt <= wrap_cnt + 1'b1;
                        end else begin
                            wr_off <= off_nx;
                        end
                    end
                end
                S_W: begin
                    if (axi.wready) begin
                        beat <= beat + 1'b1;
                        if (beat == BEAT_LAST) state <= S_B;
                    end
                end
                default: begin
                    if (axi.bvalid) begin
                        beat_cnt <= beat_cnt + 32'(BURST);
                        if (axi.bresp != 2'b00) resp_err <= 1'b1;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Every output decodes registered state only; no input reaches an output combinationally.
    assign axi.awaddr  = awaddr_r;
    assign axi.awvalid = awvalid_r;
    assign axi.awlen   = 4'(BURST - 1);
    assign axi.awsize  = 3'($clog2(DW / 8));
    assign axi.awburst = 2'b01;
    assign axi.wstrb   = '1;
    assign axi.wvalid  = (state == S_W);
    assign axi.wlast   = (state == S_W) && (beat == BEAT_LAST);
    assign axi.wdata   = (state == S_W) ? mem[rptr[AW-1:0]] : '0;
    assign axi.bready  = (state == S_B);
    assign busy        = (state != S_IDLE);
endmodule

// File: tb/tb_axi_ring_writer.sv
// Directed bench for axi_ring_writer: single burst, ring wrap, bresp error,
// FIFO overflow, en drop mid-burst and reset mid-burst.
module tb_axi_ring_writer;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] base;
    logic [31:0] size;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] wr_off;
    logic [31:0] wrap_cnt;
    logic [31:0] beat_cnt;
    logic        ovf;
    logic        resp_err;
    logic        busy;

    axi_ring_writer_if #(.DW(64)) bus ();

    axi_ring_writer #(.SW(32), .DW(64), .BURST(16), .FDEPTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .base     (base),
        .size     (size),
        .in_data  (in_data),
        .in_valid (in_valid),
        .axi      (bus),
        .wr_off   (wr_off),
        .wrap_cnt (wrap_cnt),
        .beat_cnt (beat_cnt),
        .ovf      (ovf),
        .resp_err (resp_err),
        .busy     (busy)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] sn;
    logic [31:0] aw_q[$];
    logic [63:0] w_q[$];
    int          last_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records handshakes that complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.awvalid && bus.awready) aw_q.push_back(bus.awaddr);
            if (bus.wvalid && bus.wready) begin
                if (bus.wlast) last_q.push_back(w_q.size());
                w_q.push_back(bus.wdata);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = sn;
            sn++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        if (busy) check_eq(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_beats(input string tag, input logic [31:0] n, input int budget);
        int c = 0;
        while (beat_cnt != n && c < budget) begin
            tick();
            c++;
        end
        check_eq(tag, 64'(beat_cnt), 64'(n));
    endtask

    task automatic wait_wq(input string tag, input int n, input int budget);
        int c = 0;
        while (w_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check_eq(tag, 64'(w_q.size() >= n), 64'd1);
    endtask

    task automatic restart();
        en = 1'b0;
        wait_idle("restart_idle_timeout", 500);
        tick();
        en = 1'b1;
        tick();
        sn = 0;
        aw_q.delete();
        w_q.delete();
        last_q.delete();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; base = BASE; size = 32'h400;
        in_data = '0; in_valid = 1'b0; sn = 0;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1; bus.bresp = 2'b00;
        repeat (3) tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_awvalid", 64'(bus.awvalid), 64'd0);
        check_eq("rst_wvalid", 64'(bus.wvalid), 64'd0);
        check_eq("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        check_eq("const_awlen", 64'(bus.awlen), 64'd15);
        check_eq("const_awsize", 64'(bus.awsize), 64'd3);
        check_eq("const_awburst", 64'(bus.awburst), 64'd1);
        check_eq("const_wstrb", 64'(bus.wstrb), 64'hff);
        rst = 1'b0;
        tick();

        // single burst from 32 samples
        restart();
        feed(32);
        wait_beats("t1_beat_cnt", 32'd16, 200);
        wait_idle("t1_idle_timeout", 50);
        check_eq("t1_aw_count", 64'(aw_q.size()), 64'd1);
        check_eq("t1_awaddr", 64'(aw_q[0]), 64'(BASE));
        check_eq("t1_beat0", w_q[0], 64'h00000001_00000000);
        check_eq("t1_beat15", w_q[15], 64'h0000001f_0000001e);
        check_eq("t1_wlast_count", 64'(last_q.size()), 64'd1);
        check_eq("t1_wlast_pos", 64'(last_q[0]), 64'd15);
        check_eq("t1_wr_off", 64'(wr_off), 64'h80);
        check_eq("t1_busy", 64'(busy), 64'd0);

        // nine bursts wrap the 0x400-byte ring once
        restart();
        check_eq("t2_start_wr_off", 64'(wr_off), 64'd0);
        check_eq("t2_start_beat_cnt", 64'(beat_cnt), 64'd0);
        feed(288);
        wait_beats("t2_beat_cnt", 32'd144, 500);
        check_eq("t2_aw_count", 64'(aw_q.size()), 64'd9);
        check_eq("t2_awaddr1", 64'(aw_q[1]), 64'(BASE + 32'h80));
        check_eq("t2_awaddr7", 64'(aw_q[7]), 64'(BASE + 32'h380));
        check_eq("t2_awaddr8", 64'(aw_q[8]), 64'(BASE));
        check_eq("t2_wrap_cnt", 64'(wrap_cnt), 64'd1);
        check_eq("t2_wr_off", 64'(wr_off), 64'h80);
        check_eq("t2_ovf", 64'(ovf), 64'd0);
        check_eq("t2_resp_err", 64'(resp_err), 64'd0);

        // error response still counts the beats
        restart();
        bus.bresp = 2'b10;
        feed(32);
        wait_beats("t3_beat_cnt", 32'd16, 200);
        check_eq("t3_resp_err", 64'(resp_err), 64'd1);
        bus.bresp = 2'b00;

        // overflow with the slave stalled
        restart();
        bus.awready = 1'b0; bus.wready = 1'b0;
        feed(128);
        tick(); tick();
        check_eq("t4_full_no_ovf", 64'(ovf), 64'd0);
        check_eq("t4_awvalid_held", 64'(bus.awvalid), 64'd1);
        check_eq("t4_awaddr_held", 64'(bus.awaddr), 64'(BASE));
        feed(72);
        tick(); tick();
        check_eq("t4_ovf", 64'(ovf), 64'd1);
        bus.awready = 1'b1; bus.wready = 1'b1;
        wait_beats("t4_beat_cnt", 32'd64, 500);
        wait_idle("t4_idle_timeout", 50);
        check_eq("t4_w_count", 64'(w_q.size()), 64'd64);
        check_eq("t4_word0", w_q[0], 64'h00000001_00000000);
        check_eq("t4_word40", w_q[40], 64'h00000051_00000050);
        check_eq("t4_word63", w_q[63], 64'h0000007f_0000007e);
        check_eq("t4_aw3", 64'(aw_q[3]), 64'(BASE + 32'h180));
        check_eq("t4_ovf_sticky", 64'(ovf), 64'd1);

        // en dropped mid-burst: burst completes, then restart clears state
        restart();
        check_eq("t5_start_ovf", 64'(ovf), 64'd0);
        check_eq("t5_start_beat_cnt", 64'(beat_cnt), 64'd0);
        feed(32);
        wait_wq("t5_beat5_timeout", 5, 200);
        en = 1'b0;
        wait_idle("t5_idle_timeout", 100);
        check_eq("t5_w_count", 64'(w_q.size()), 64'd16);
        check_eq("t5_beat_cnt", 64'(beat_cnt), 64'd16);
        check_eq("t5_wlast_pos", 64'(last_q[0]), 64'd15);
        check_eq("t5_busy", 64'(busy), 64'd0);
        restart();
        check_eq("t5_re_wr_off", 64'(wr_off), 64'd0);
        check_eq("t5_re_beat_cnt", 64'(beat_cnt), 64'd0);
        check_eq("t5_re_wrap_cnt", 64'(wrap_cnt), 64'd0);

        // reset in the middle of the W phase
        feed(32);
        wait_wq("t6_beat3_timeout", 3, 200);
        check_eq("t6_pre_wr_off", 64'(wr_off), 64'h80);
        rst = 1'b1;
        tick();
        check_eq("t6_wvalid", 64'(bus.wvalid), 64'd0);
        check_eq("t6_awvalid", 64'(bus.awvalid), 64'd0);
        check_eq("t6_bready", 64'(bus.bready), 64'd0);
        check_eq("t6_busy", 64'(busy), 64'd0);
        check_eq("t6_wr_off", 64'(wr_off), 64'd0);
        check_eq("t6_beat_cnt", 64'(beat_cnt), 64'd0);
        check_eq("t6_wrap_cnt", 64'(wrap_cnt), 64'd0);
        check_eq("t6_wdata", bus.wdata, 64'd0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
